hybrid_cache_memarb: RTL and testbench

HYBRID_CACHE_MEMARB -- requirements
Module: hybrid_cache_memarb

---
 rtl/hybrid_cache_pkg.sv | 5 +
 rtl/hybrid_cache_rrpick.sv | 26 ++
 rtl/hybrid_cache_memarb.sv | 101 ++++++++++
 tb/tb_hybrid_cache_memarb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_cache_pkg.sv
// hybrid_cache_pkg: shared arbiter state encoding and burst-length default
package hybrid_cache_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_e;
  localparam int BURSTLEN_DEF = 16;
endpackage

// File: rtl/hybrid_cache_rrpick.sv
// hybrid_cache_rrpick: combinational round-robin picker, first requester at or after i_ptr wins
module hybrid_cache_rrpick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);
  logic          w_found;
  logic [IW-1:0] w_c;
  always_comb begin
    w_found = 1'b0;
    w_c     = '0;
    o_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_c = IW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_c]) begin
        w_found = 1'b1;
        o_idx   = w_c;
      end
    end
    o_onehot = w_found ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/hybrid_cache_memarb.sv
// hybrid_cache_memarb: round-robin arbiter sharing one memory port among NLINES cache lines.
// Define HYBRID_CACHE_MEMARB_STATS_EN to add per-line saturating grant counters on arb_grant_cnt.
module hybrid_cache_memarb
  import hybrid_cache_pkg::*;
#(
  parameter int NLINES   = 4,
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32,
  parameter int BURSTLEN = BURSTLEN_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NLINES*ADDRBITS-1:0]   line_mem_addr,
  input  logic [NLINES*DATABITS-1:0]   line_mem_in,
  input  logic [NLINES-1:0]            line_mem_rdreq,
  input  logic [NLINES-1:0]            line_mem_wrreq,
  output logic [NLINES-1:0]            line_mem_out_valid,
  output logic [NLINES-1:0]            line_pause,
  output logic [DATABITS-1:0]          line_mem_out,
  output logic [ADDRBITS-1:0]          mem_addr,
  output logic [DATABITS-1:0]          mem_in,
  output logic                         mem_rdreq,
  output logic                         mem_wrreq,
  input  logic [DATABITS-1:0]          mem_out,
  input  logic                         mem_out_valid
`ifdef HYBRID_CACHE_MEMARB_STATS_EN
  , output logic [NLINES*16-1:0]       arb_grant_cnt
`endif
);
  localparam int IW = (NLINES > 1) ? $clog2(NLINES) : 1;
  localparam int CW = $clog2(BURSTLEN + 1);
  localparam logic [IW-1:0] LAST = IW'(NLINES - 1);
  arb_state_e        r_state;
  logic [IW-1:0]     r_gnt_idx, r_rr_ptr, r_rd_tag, w_pick_idx;
  logic [CW-1:0]     r_beat_cnt;
  logic              r_rd_tag_valid, w_any, w_grant, w_g_req, w_beat, w_exit;
  logic [NLINES-1:0] w_pick_onehot;

  hybrid_cache_rrpick #(.N(NLINES), .IW(IW)) u_pick (
    .i_req    (line_mem_rdreq | line_mem_wrreq),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  // Outputs are gated by reset so the reset cycle itself is already quiet
  assign w_any        = |w_pick_onehot;
  assign w_grant      = !reset && r_state == GRANT;
  assign w_g_req      = line_mem_rdreq[r_gnt_idx] | line_mem_wrreq[r_gnt_idx];
  assign w_beat       = w_grant && w_g_req;
  assign w_exit       = !w_g_req || r_beat_cnt == CW'(BURSTLEN - 1);
  assign mem_addr     = line_mem_addr[r_gnt_idx*ADDRBITS +: ADDRBITS];
  assign mem_in       = line_mem_in[r_gnt_idx*DATABITS +: DATABITS];
  assign mem_rdreq    = w_grant && line_mem_rdreq[r_gnt_idx];
  assign mem_wrreq    = w_grant && line_mem_wrreq[r_gnt_idx];
  assign line_pause   = w_grant ? ~(NLINES'(1) << r_gnt_idx) : '1;
  assign line_mem_out = mem_out;

  always_comb begin
    line_mem_out_valid = '0;
    if (!reset && mem_out_valid && r_rd_tag_valid) line_mem_out_valid[r_rd_tag] = 1'b1;
  end

  always_ff @(posedge clk)
    if (reset) begin
      r_state        <= IDLE;
      r_gnt_idx      <= '0;
      r_rr_ptr       <= '0;
      r_beat_cnt     <= '0;
      r_rd_tag       <= '0;
      r_rd_tag_valid <= 1'b0;
    end else begin
      r_rd_tag_valid <= mem_rdreq && !mem_wrreq;
      if (mem_rdreq) r_rd_tag <= r_gnt_idx;
      case (r_state)
        IDLE: if (w_any) begin
          r_gnt_idx  <= w_pick_idx;
          r_beat_cnt <= '0;
          r_state    <= GRANT;
        end
        GRANT: begin
          if (w_beat && r_beat_cnt != CW'(BURSTLEN)) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (w_exit) begin
            r_state  <= DRAIN;
            r_rr_ptr <= r_gnt_idx == LAST ? '0 : r_gnt_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end

`ifdef HYBRID_CACHE_MEMARB_STATS_EN
  logic [NLINES*16-1:0] r_grant_cnt;
  always_ff @(posedge clk)
    for (int i = 0; i < NLINES; i++)
      if (reset) r_grant_cnt[i*16 +: 16] <= '0;
      else if (r_state == IDLE && w_pick_onehot[i] && r_grant_cnt[i*16 +: 16] != 16'hFFFF)
        r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 1'b1;
  assign arb_grant_cnt = r_grant_cnt;
`endif
endmodule

// File: tb/tb_hybrid_cache_memarb.sv
// tb_hybrid_cache_memarb: directed scenarios checked against a cycle-level arbitration model
module tb_hybrid_cache_memarb;
  localparam int NL = 4;
  localparam int BL = 16;
  localparam logic [31:0] KEY = 32'h5A5A_F00F;

  logic          clk = 1'b0, reset = 1'b1;
  logic [127:0]  line_mem_addr = '0, line_mem_in = '0;
  logic [3:0]    line_mem_rdreq = '0, line_mem_wrreq = '0;
  logic [3:0]    line_mem_out_valid, line_pause;
  logic [31:0]   line_mem_out, mem_addr, mem_in;
  logic          mem_rdreq, mem_wrreq;
  logic [31:0]   mem_out = '0;
  logic          mem_out_valid = 1'b0;
`ifdef HYBRID_CACHE_MEMARB_STATS_EN
  logic [63:0]   arb_grant_cnt;
`endif

  hybrid_cache_memarb dut (
    .clk(clk), .reset(reset),
    .line_mem_addr(line_mem_addr), .line_mem_in(line_mem_in),
    .line_mem_rdreq(line_mem_rdreq), .line_mem_wrreq(line_mem_wrreq),
    .line_mem_out_valid(line_mem_out_valid), .line_pause(line_pause),
    .line_mem_out(line_mem_out), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
    .mem_out(mem_out), .mem_out_valid(mem_out_valid)
`ifdef HYBRID_CACHE_MEMARB_STATS_EN
    , .arb_grant_cnt(arb_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: who owns the port, a one-cycle gap after each release, fairness pointer, pending read owner
  int m_owner = -1, m_beats = 0, m_ptr = 0, m_tag = -1;
  bit m_drain = 0;
  int m_gcnt[NL];
  // line agents: outstanding words per line
  int rem[NL], done[NL];
  bit wr_mode[NL], both[NL];
  logic [31:0] base[NL];

  always @(posedge clk) begin
    int o;
    bit r, w;
    if (reset) begin
      m_owner = -1; m_drain = 0; m_ptr = 0; m_tag = -1; m_beats = 0;
      for (int i = 0; i < NL; i++) m_gcnt[i] = 0;
    end else begin
      o = m_owner;
      r = (o >= 0) ? line_mem_rdreq[o] : 1'b0;
      w = (o >= 0) ? line_mem_wrreq[o] : 1'b0;
      m_tag = (r && !w) ? o : -1;
      if (o >= 0) begin
        if (r || w) begin done[o]++; rem[o]--; m_beats++; end
        if (!(r || w) || m_beats == BL) begin m_owner = -1; m_drain = 1; m_ptr = (o + 1) % NL; end
      end else if (m_drain) m_drain = 0;
      else
        for (int k = 0; k < NL; k++)
          if (m_owner < 0 && (line_mem_rdreq[(m_ptr + k) % NL] || line_mem_wrreq[(m_ptr + k) % NL])) begin
            m_owner = (m_ptr + k) % NL; m_beats = 0; m_gcnt[m_owner]++;
          end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ep, eov;
    logic er, ew;
    ep = 4'hF; eov = '0; er = 0; ew = 0;
    if (!reset && m_owner >= 0) begin
      ep[m_owner] = 1'b0;
      er = line_mem_rdreq[m_owner];
      ew = line_mem_wrreq[m_owner];
      check("mem_addr", mem_addr, line_mem_addr[m_owner*32 +: 32]);
      check("mem_in", mem_in, line_mem_in[m_owner*32 +: 32]);
    end
    if (!reset && mem_out_valid && m_tag >= 0) eov[m_tag] = 1'b1;
    check("line_pause", line_pause, ep);
    check("mem_rdreq", mem_rdreq, er);
    check("mem_wrreq", mem_wrreq, ew);
    check("out_valid", line_mem_out_valid, eov);
    check("line_mem_out", line_mem_out, mem_out);
`ifdef HYBRID_CACHE_MEMARB_STATS_EN
    if (!reset) for (int i = 0; i < NL; i++) check("grant_cnt", arb_grant_cnt[i*16 +: 16], 64'(m_gcnt[i]));
`endif
  end

  logic [3:0]  s_pause, s_ov;
  logic        s_rd, s_wr;
  logic [31:0] s_lmo;

  task automatic drive();
    for (int i = 0; i < NL; i++) begin
      line_mem_rdreq[i] = rem[i] > 0 && (!wr_mode[i] || both[i]);
      line_mem_wrreq[i] = rem[i] > 0 && wr_mode[i];
      line_mem_addr[i*32 +: 32] = base[i] + 32'(done[i]);
      line_mem_in[i*32 +: 32]   = 32'hD000_0000 + 32'(i << 16) + 32'(done[i]);
    end
  endtask

  task automatic req(input int i, input int n, input logic [31:0] b, input bit wr, input bit bo);
    rem[i] = n; done[i] = 0; base[i] = b; wr_mode[i] = wr; both[i] = bo;
  endtask

  // one cycle: sample outputs mid-cycle, then a one-cycle-latency memory answers pure reads
  task automatic step(input bit stray);
    logic rd;
    logic [31:0] a;
    @(negedge clk);
    rd = mem_rdreq && !mem_wrreq; a = mem_addr;
    s_pause = line_pause; s_ov = line_mem_out_valid; s_rd = mem_rdreq; s_wr = mem_wrreq; s_lmo = line_mem_out;
    @(posedge clk);
    #1;
    mem_out_valid = rd | stray;
    mem_out = a ^ KEY;
    drive();
  endtask

  function automatic int owner_of(logic [3:0] p);
    int r = -1;
    for (int i = 0; i < NL; i++) if (!p[i]) r = (r == -1) ? i : 99;
    return r;
  endfunction

  int g_line[$], g_len[$];
  int ov_cnt;
  logic [3:0] first_ov;
  logic [31:0] first_ov_data;

  task automatic run(input int n);
    int last, cur;
    last = -1; ov_cnt = 0; first_ov = '0; first_ov_data = '0;
    g_line.delete(); g_len.delete();
    for (int c = 0; c < n; c++) begin
      step(0);
      cur = owner_of(s_pause);
      if (cur >= 0) begin
        if (cur != last) begin g_line.push_back(cur); g_len.push_back(1); end
        else g_len[g_len.size()-1]++;
      end
      if (s_ov != 0) begin
        if (ov_cnt == 0) begin first_ov = s_ov; first_ov_data = s_lmo; end
        ov_cnt++;
      end
      last = cur;
    end
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin rem[i] = 0; done[i] = 0; wr_mode[i] = 0; both[i] = 0; base[i] = '0; end
    drive();
    step(0); step(0);
    check("rst_pause", s_pause, 4'hF);
    check("rst_rd", s_rd, 0);
    check("rst_wr", s_wr, 0);
    check("rst_ov", s_ov, 0);
    reset = 0;
    // single 16-word write burst from line 0
    req(0, 16, 32'h8000_0000, 1, 0); drive();
    run(22);
    check("b033_runs", g_line.size(), 1);
    check("b033_line", g_line[0], 0);
    check("b033_len", g_len[0], 16);
    check("b033_words", done[0], 16);
    check("b033_idle", s_pause, 4'hF);
    // lines 1 and 2 together after reset
    reset = 1; step(0); reset = 0;
    req(1, 3, 32'h0000_1000, 0, 0); req(2, 2, 32'h0000_2000, 1, 0); drive();
    run(16);
    check("b034_runs", g_line.size(), 2);
    check("b034_first", g_line[0], 1);
    check("b034_second", g_line[1], 2);
    check("b034_len1", g_len[0], 4);
    check("b034_len2", g_len[1], 3);
    check("b034_reads", ov_cnt, 3);
    // 20-word read hits the burst limit, line 2 is served before line 0 resumes
    req(0, 20, 32'h0000_0100, 0, 0); req(2, 2, 32'h0000_2100, 1, 0); drive();
    run(36);
    check("b035_runs", g_line.size(), 3);
    check("b035_l0", g_line[0], 0);
    check("b035_len0", g_len[0], 16);
    check("b035_l1", g_line[1], 2);
    check("b035_l2", g_line[2], 0);
    check("b035_len2", g_len[2], 5);
    check("b035_reads", ov_cnt, 20);
    // line 3 read while line 0 waits
    req(3, 1, 32'h8000_0010, 0, 0); req(0, 1, 32'h0000_0200, 0, 0); drive();
    run(14);
    check("b036_first", g_line[0], 3);
    check("b036_ov", first_ov, 4'b1000);
    check("b036_data", first_ov_data, 32'h8000_0010 ^ KEY);
    check("b036_then0", g_line[1], 0);
    // untagged memory valid is ignored
    step(1); step(0);
    check("stray_ov", s_ov, 0);
    // simultaneous read+write forwards both and tags nothing
    req(1, 2, 32'h0000_4000, 1, 1); drive();
    run(8);
    check("both_line", g_line[0], 1);
    check("both_len", g_len[0], 3);
    check("both_noov", ov_cnt, 0);
    // reset mid-burst
    req(1, 10, 32'h0000_5000, 0, 0); drive();
    step(0); step(0); step(0);
    check("b037_granted", s_pause, 4'b1101);
    reset = 1; rem[1] = 0; drive();
    step(0);
    check("b037_pause", s_pause, 4'hF);
    check("b037_rd", s_rd, 0);
    check("b037_ov", s_ov, 0);
    reset = 0;
    step(0);
    check("b037_pause2", s_pause, 4'hF);
    check("b037_ov2", s_ov, 0);
    // three separate grants to line 2
    for (int k = 0; k < 3; k++) begin
      req(2, 1, 32'h0000_3000 + 32'(k * 16), 0, 0); drive();
      run(6);
      check("b038_line", g_line[0], 2);
    end
    check("b038_model", m_gcnt[2], 3);
`ifdef HYBRID_CACHE_MEMARB_STATS_EN
    check("b038_cnt", arb_grant_cnt[47:32], 3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
